// File: rtl/key_event_fifo_if.sv
// Key event stream interface: show-ahead event head plus consumer ready.
// Ports: evt_valid (head valid), evt_code (key index at head), evt_ready (consumer accept).
// Modports: master = event producer (FIFO), slave = event consumer.
interface key_event_fifo_if #(
  parameter int CODE_W = 2
);
  logic              evt_valid;
  logic              evt_ready;
  logic [CODE_W-1:0] evt_code;

  modport master (output evt_valid, output evt_code, input evt_ready);
  modport slave  (input evt_valid, input evt_code, output evt_ready);
endinterface

// File: rtl/key_event_fifo.sv
// Serialises per-key press pulses into encoded key indices buffered in a show-ahead FIFO.
// Latency: pulse in cycle t -> evt_valid during cycle t+2 (pending stage, then FIFO write).
// Backpressure: while full, pending bits wait for space; a repeat press on a waiting key sets sticky ovf.
// Ports: clk, rst_n (async active-low), key_pulse[N], evt (master modport: evt_valid/evt_code/evt_ready),
//        ovf (sticky lost-event flag), ovf_clr (synchronous clear, loses to a simultaneous set).
module key_event_fifo #(
  parameter int N      = 4,
  parameter int CODE_W = 2,
  parameter int DEPTH  = 4,
  parameter int PTR_W  = 2
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [N-1:0]            key_pulse,
  key_event_fifo_if.master        evt,
  output logic                    ovf,
  input  logic                    ovf_clr
);

  localparam logic [PTR_W:0] LP_DEPTH = (PTR_W+1)'(DEPTH);

  logic [N-1:0]      r_pending;
  logic [CODE_W-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0]  r_wr_ptr;
  logic [PTR_W-1:0]  r_rd_ptr;
  logic [PTR_W:0]    r_count;
  logic              r_ovf;

  logic              w_pop;
  logic              w_push_ok;
  logic              w_push;
  logic [N-1:0]      w_low;
  logic [CODE_W-1:0] w_low_idx;
  logic [N-1:0]      w_grant;
  logic              w_ovf_set;

  // Pop only when the head is valid; ready on an empty FIFO is ignored.
  assign w_pop     = (r_count != '0) & evt.evt_ready;
  // A same-cycle pop frees the slot the push needs, so full+pop still accepts.
  assign w_push_ok = (r_count < LP_DEPTH) | w_pop;

  // Lowest-index pending key wins; scanning downward leaves the lowest hit last.
  always_comb begin
    w_low     = '0;
    w_low_idx = '0;
    for (int i = N-1; i >= 0; i--) begin
      if (r_pending[i]) begin
        w_low     = '0;
        w_low[i]  = 1'b1;
        w_low_idx = CODE_W'(i);
      end
    end
  end

  assign w_grant = w_push_ok ? w_low : '0;
  assign w_push  = |w_grant;

  // A new press on a key still waiting (and not leaving this cycle) merges and is lost.
  assign w_ovf_set = |(key_pulse & r_pending & ~w_grant);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pending <= '0;
      r_wr_ptr  <= '0;
      r_rd_ptr  <= '0;
      r_count   <= '0;
      r_ovf     <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else begin
      r_pending <= (r_pending & ~w_grant) | key_pulse;

      if (w_push) begin
        r_mem[r_wr_ptr] <= w_low_idx;
        r_wr_ptr        <= r_wr_ptr + PTR_W'(1);
      end

      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      end

      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + (PTR_W+1)'(1);
        2'b01:   r_count <= r_count - (PTR_W+1)'(1);
        default: r_count <= r_count;
      endcase

      if (w_ovf_set) begin
        r_ovf <= 1'b1;
      end else if (ovf_clr) begin
        r_ovf <= 1'b0;
      end
    end
  end

  assign evt.evt_valid = (r_count != '0);
  assign evt.evt_code  = r_mem[r_rd_ptr];
  assign ovf           = r_ovf;

endmodule

// File: tb/tb_key_event_fifo.sv
// Testbench for key_event_fifo: directed vector table, hand-written corner sequences,
// and randomized traffic compared against a queue-based reference model.
module tb_key_event_fifo;
  localparam int N      = 4;
  localparam int CODE_W = 2;
  localparam int DEPTH  = 4;
  localparam int PTR_W  = 2;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [N-1:0] key_pulse;
  logic         ovf;
  logic         ovf_clr;

  key_event_fifo_if #(.CODE_W(CODE_W)) evt_if ();

  key_event_fifo #(.N(N), .CODE_W(CODE_W), .DEPTH(DEPTH), .PTR_W(PTR_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .key_pulse (key_pulse),
    .evt       (evt_if.master),
    .ovf       (ovf),
    .ovf_clr   (ovf_clr)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model: set of waiting keys, FIFO contents as a queue, sticky flag.
  bit m_pend [N];
  int q [$];
  bit m_ovf;

  typedef struct {
    logic [N-1:0]      kp;
    logic              rdy;
    logic              ev;
    logic [CODE_W-1:0] ec;
  } vec_t;

  vec_t tbl [10];

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < N; i++) m_pend[i] = 1'b0;
    q.delete();
    m_ovf = 1'b0;
  endtask

  task automatic model_edge(input logic [N-1:0] kp, input logic rdy, input logic clr);
    bit pop;
    bit set;
    int g;
    pop = (q.size() != 0) && rdy;
    g = -1;
    if (q.size() < DEPTH || pop) begin
      for (int i = 0; i < N; i++) if (m_pend[i] && g < 0) g = i;
    end
    set = 1'b0;
    for (int i = 0; i < N; i++) if (kp[i] && m_pend[i] && i != g) set = 1'b1;
    if (pop) void'(q.pop_front());
    if (g >= 0) begin
      q.push_back(g);
      m_pend[g] = 1'b0;
    end
    for (int i = 0; i < N; i++) if (kp[i]) m_pend[i] = 1'b1;
    if (set) m_ovf = 1'b1;
    else if (clr) m_ovf = 1'b0;
  endtask

  // One clock cycle: called at posedge+1, drives inputs, samples at mid-cycle,
  // checks against the model, advances the model and returns at the next posedge+1.
  task automatic cyc(input logic [N-1:0] kp, input logic rdy, input logic clr,
                     output logic v, output logic [CODE_W-1:0] c);
    key_pulse        = kp;
    evt_if.evt_ready = rdy;
    ovf_clr          = clr;
    #4;
    v = evt_if.evt_valid;
    c = evt_if.evt_code;
    chk("mdl_valid", int'(v), int'(q.size() != 0));
    if (q.size() != 0) chk("mdl_code", int'(c), q[0]);
    chk("mdl_ovf", int'(ovf), int'(m_ovf));
    model_edge(kp, rdy, clr);
    @(posedge clk);
    #1;
  endtask

  // Pulse each key in 'seq' (2 bits per entry) on separate cycles with ready low.
  task automatic fill(input int n, input logic [15:0] seq);
    logic v;
    logic [CODE_W-1:0] c;
    logic [15:0] s;
    logic [N-1:0] kp;
    s = seq;
    for (int i = 0; i < n; i++) begin
      kp = '0;
      kp[s[2*i +: 2]] = 1'b1;
      cyc(kp, 1'b0, 1'b0, v, c);
      cyc('0, 1'b0, 1'b0, v, c);
    end
  endtask

  // Drain with ready high and compare the accepted codes to 'exp' in order.
  task automatic drain_expect(input string nm, input int n, input logic [15:0] exp);
    logic v;
    logic [CODE_W-1:0] c;
    logic [15:0] e;
    int got;
    e = exp;
    got = 0;
    for (int k = 0; k < 20 && got < n; k++) begin
      cyc('0, 1'b1, 1'b0, v, c);
      if (v) begin
        chk(nm, int'(c), int'(e[2*got +: 2]));
        got++;
      end
    end
    chk({nm, "_cnt"}, got, n);
  endtask

  initial begin
    logic v;
    logic [CODE_W-1:0] c;
    logic [N-1:0] kp;

    // Single press of key 2, then simultaneous press of keys 0,1,3; ready held high.
    tbl[0] = '{4'b0100, 1'b1, 1'b0, 2'd0};
    tbl[1] = '{4'b0000, 1'b1, 1'b0, 2'd0};
    tbl[2] = '{4'b0000, 1'b1, 1'b1, 2'd2};
    tbl[3] = '{4'b0000, 1'b1, 1'b0, 2'd0};
    tbl[4] = '{4'b1011, 1'b1, 1'b0, 2'd0};
    tbl[5] = '{4'b0000, 1'b1, 1'b0, 2'd0};
    tbl[6] = '{4'b0000, 1'b1, 1'b1, 2'd0};
    tbl[7] = '{4'b0000, 1'b1, 1'b1, 2'd1};
    tbl[8] = '{4'b0000, 1'b1, 1'b1, 2'd3};
    tbl[9] = '{4'b0000, 1'b1, 1'b0, 2'd0};

    rst_n            = 1'b0;
    key_pulse        = '0;
    ovf_clr          = 1'b0;
    evt_if.evt_ready = 1'b0;
    model_reset();
    #2;
    chk("rst_valid", int'(evt_if.evt_valid), 0);
    chk("rst_code",  int'(evt_if.evt_code), 0);
    chk("rst_ovf",   int'(ovf), 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    for (int i = 0; i < 10; i++) begin
      cyc(tbl[i].kp, tbl[i].rdy, 1'b0, v, c);
      chk("tbl_valid", int'(v), int'(tbl[i].ev));
      if (tbl[i].ev) chk("tbl_code", int'(c), int'(tbl[i].ec));
    end

    // Fill and stall: keys 0,1,2,3,0 -> four buffered, key 0 waits.
    fill(5, 16'b00_11_10_01_00);
    cyc('0, 1'b0, 1'b0, v, c);
    chk("fill_valid", int'(v), 1);
    chk("fill_code",  int'(c), 0);
    drain_expect("fill_drain", 5, 16'b00_11_10_01_00);
    chk("fill_ovf", int'(ovf), 0);

    // Overflow: full FIFO, key 1 pressed twice while waiting.
    fill(4, 16'b11_10_01_00);
    cyc(4'b0010, 1'b0, 1'b0, v, c);
    chk("ovf_first", int'(ovf), 0);
    cyc(4'b0000, 1'b0, 1'b0, v, c);
    cyc(4'b0010, 1'b0, 1'b0, v, c);
    chk("ovf_set", int'(ovf), 1);
    drain_expect("ovf_drain", 5, 16'b01_11_10_01_00);
    chk("ovf_sticky", int'(ovf), 1);
    cyc('0, 1'b0, 1'b1, v, c);
    chk("ovf_clr", int'(ovf), 0);

    // Clear coincident with a new collision: set wins.
    fill(4, 16'b11_10_01_00);
    cyc(4'b0100, 1'b0, 1'b0, v, c);
    cyc(4'b0000, 1'b0, 1'b0, v, c);
    cyc(4'b0100, 1'b0, 1'b1, v, c);
    chk("ovf_set_wins", int'(ovf), 1);

    // Full with key 2 waiting: one pop lets key 2 enter in the same cycle.
    cyc('0, 1'b1, 1'b0, v, c);
    chk("fpp_head", int'(c), 0);
    cyc('0, 1'b0, 1'b0, v, c);
    chk("fpp_valid", int'(v), 1);
    chk("fpp_newhead", int'(c), 1);
    drain_expect("fpp_drain", 4, 16'b10_11_10_01);

    // Async reset mid-operation: 3 buffered, keys 0 and 2 pending, ovf still set.
    fill(3, 16'b10_01_00);
    cyc(4'b0101, 1'b0, 1'b0, v, c);
    key_pulse = '0;
    chk("pre_rst_ovf", int'(ovf), 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_valid", int'(evt_if.evt_valid), 0);
    chk("arst_code",  int'(evt_if.evt_code), 0);
    chk("arst_ovf",   int'(ovf), 0);
    model_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      cyc('0, 1'b1, 1'b0, v, c);
      chk("post_rst_idle", int'(v), 0);
    end

    // Randomized traffic against the model; bursts of low ready exercise full/overflow.
    for (int i = 0; i < 600; i++) begin
      logic rdy;
      for (int b = 0; b < N; b++) kp[b] = ($urandom_range(3) == 0);
      rdy = ((i / 50) % 2 == 0) ? ($urandom_range(3) != 0) : ($urandom_range(3) == 0);
      cyc(kp, rdy, ($urandom_range(15) == 0), v, c);
    end
    for (int i = 0; i < 12; i++) cyc('0, 1'b1, 1'b0, v, c);
    chk("rand_empty", int'(evt_if.evt_valid), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
